// File: rtl/trigger_pkg.sv
// trigger_pkg: state encoding and default timing shared by the trigger conditioner blocks.
package trigger_pkg;
  localparam int DEBOUNCE_DEF = 500000;
  localparam int COOLDOWN_DEF = 10000000;
  localparam int HOLD_ERR_DEF = 200000000;
  localparam int CNT_W_DEF = 28;
  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    FIRE,
    HELD,
    DB_RELEASE,
    COOLDOWN,
    JAM
  } state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level, cleared by reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  assign o_q = r_sync;
endmodule

// File: rtl/trigger_conditioner.sv
// trigger_conditioner: turns a bouncing trigger button into one registered shot per press,
// with release debounce, post-shot cooldown and a jam flag for a trigger held too long.
module trigger_conditioner
  import trigger_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int COOLDOWN_CYCLES = COOLDOWN_DEF,
  parameter int HOLD_ERR_CYCLES = HOLD_ERR_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic trig_raw,
  input  logic arm,
  output logic fire,
  output logic error,
  output logic busy
);
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CD_MAX = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_ERR_CYCLES - 1);
  logic w_trig;
  state_t w_next;
  state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic r_fire;
  logic r_error;
  logic r_busy;
  sync_2ff u_sync (
    .clk  (clk),
    .reset(reset),
    .i_d  (trig_raw),
    .o_q  (w_trig)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (w_trig && arm) w_next = DB_PRESS;
      DB_PRESS:   w_next = (!w_trig || !arm) ? IDLE : (r_cnt == DB_MAX) ? FIRE : DB_PRESS;
      FIRE:       w_next = HELD;
      HELD:       w_next = !w_trig ? DB_RELEASE : (r_cnt == HOLD_MAX) ? JAM : HELD;
      DB_RELEASE: w_next = w_trig ? HELD : (r_cnt == DB_MAX) ? COOLDOWN : DB_RELEASE;
      COOLDOWN:   if (r_cnt == CD_MAX) w_next = IDLE;
      JAM:        if (!w_trig && r_cnt == DB_MAX) w_next = COOLDOWN;
      default:    w_next = IDLE;
    endcase
  end
  // In JAM the counter only accumulates consecutive low samples, so any high sample restarts it.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_fire <= 1'b0;
      r_error <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_next != r_state || (r_state == JAM && w_trig)) ? '0 :
               (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
      r_fire <= w_next == FIRE;
      r_error <= w_next == JAM;
      r_busy <= w_next != IDLE;
    end
  assign fire = r_fire;
  assign error = r_error;
  assign busy = r_busy;
endmodule

// File: tb/tb_trigger_conditioner.sv
// tb_trigger_conditioner: directed scenarios with hand-timed expectations, DEBOUNCE=4, COOLDOWN=8, HOLD_ERR=20.
module tb_trigger_conditioner;
  logic clk;
  logic reset;
  logic trig_raw;
  logic arm;
  logic fire;
  logic error;
  logic busy;
  int n_tests;
  int n_fail;

  trigger_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .COOLDOWN_CYCLES(8),
    .HOLD_ERR_CYCLES(20),
    .CNT_W(8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .trig_raw(trig_raw),
    .arm     (arm),
    .fire    (fire),
    .error   (error),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    trig_raw = 1'b0;
    arm = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    pulses = 0;
    reset = 1'b1;
    trig_raw = 1'b1;
    arm = 1'b1;
    step();
    step();
    n_tests += 3;
    if (fire !== 1'b0) begin n_fail++; $display("FAIL reset_fire got=%b exp=0", fire); end
    if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b exp=0", error); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      pulses += int'(fire);
      n_tests++;
      if (fire !== (k == 7)) begin n_fail++; $display("FAIL reset_hold_fire k=%0d got=%b exp=%b", k, fire, k == 7); end
    end
    n_tests++;
    if (pulses != 1) begin n_fail++; $display("FAIL reset_hold_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_clean();
    int pulses;
    pulses = 0;
    do_reset();
    trig_raw = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      pulses += int'(fire);
      n_tests += 3;
      if (fire !== (k == 7)) begin n_fail++; $display("FAIL clean_fire k=%0d got=%b exp=%b", k, fire, k == 7); end
      if (busy !== (k >= 3 && k <= 24)) begin n_fail++; $display("FAIL clean_busy k=%0d got=%b exp=%b", k, busy, k >= 3 && k <= 24); end
      if (error !== 1'b0) begin n_fail++; $display("FAIL clean_error k=%0d got=%b exp=0", k, error); end
      if (k == 10) trig_raw = 1'b0;
    end
    n_tests++;
    if (pulses != 1) begin n_fail++; $display("FAIL clean_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_bounce();
    int pulses;
    pulses = 0;
    do_reset();
    for (int j = 0; j <= 36; j++) begin
      trig_raw = (j < 9) ? (j % 3 != 2) : (j <= 20);
      step();
      pulses += int'(fire);
      n_tests++;
      if (fire !== (j + 1 == 16)) begin n_fail++; $display("FAIL bounce_fire k=%0d got=%b exp=%b", j + 1, fire, j + 1 == 16); end
    end
    n_tests += 2;
    if (pulses != 1) begin n_fail++; $display("FAIL bounce_pulses got=%0d exp=1", pulses); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bounce_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_jam();
    do_reset();
    trig_raw = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      step();
      n_tests += 3;
      if (fire !== (k == 7)) begin n_fail++; $display("FAIL jam_fire k=%0d got=%b exp=%b", k, fire, k == 7); end
      if (error !== (k >= 28 && k <= 42)) begin n_fail++; $display("FAIL jam_error k=%0d got=%b exp=%b", k, error, k >= 28 && k <= 42); end
      if (busy !== (k >= 3 && k <= 50)) begin n_fail++; $display("FAIL jam_busy k=%0d got=%b exp=%b", k, busy, k >= 3 && k <= 50); end
      if (k == 10) arm = 1'b0;
      if (k == 37) trig_raw = 1'b0;
    end
    arm = 1'b1;
  endtask

  task automatic test_cooldown();
    logic exp_busy;
    do_reset();
    for (int k = 1; k <= 56; k++) begin
      trig_raw = (k - 1 <= 9) || (k - 1 >= 15 && k - 1 <= 39);
      step();
      exp_busy = (k >= 3 && k <= 24) || (k >= 26 && k <= 54);
      n_tests += 2;
      if (fire !== (k == 7 || k == 30)) begin n_fail++; $display("FAIL cooldown_fire k=%0d got=%b exp=%b", k, fire, k == 7 || k == 30); end
      if (busy !== exp_busy) begin n_fail++; $display("FAIL cooldown_busy k=%0d got=%b exp=%b", k, busy, exp_busy); end
    end
  endtask

  task automatic test_arm();
    do_reset();
    arm = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      trig_raw = (k - 1 <= 9);
      step();
      n_tests += 2;
      if (fire !== 1'b0) begin n_fail++; $display("FAIL disarmed_fire k=%0d got=%b exp=0", k, fire); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL disarmed_busy k=%0d got=%b exp=0", k, busy); end
    end
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      trig_raw = (k - 1 <= 14);
      step();
      n_tests += 2;
      if (fire !== 1'b0) begin n_fail++; $display("FAIL arm_drop_fire k=%0d got=%b exp=0", k, fire); end
      if (busy !== (k == 3 || k == 4)) begin n_fail++; $display("FAIL arm_drop_busy k=%0d got=%b exp=%b", k, busy, k == 3 || k == 4); end
      if (k == 4) arm = 1'b0;
    end
    arm = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    trig_raw = 1'b1;
    for (int k = 1; k <= 7; k++) step();
    n_tests++;
    if (fire !== 1'b1) begin n_fail++; $display("FAIL midfire_pre got=%b exp=1", fire); end
    reset = 1'b1;
    trig_raw = 1'b0;
    #1;
    n_tests += 2;
    if (fire !== 1'b0) begin n_fail++; $display("FAIL midfire_trunc got=%b exp=0", fire); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midfire_busy got=%b exp=0", busy); end
    step();
    step();
    reset = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      n_tests++;
      if (fire !== 1'b0) begin n_fail++; $display("FAIL midfire_after k=%0d got=%b exp=0", k, fire); end
    end
    trig_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_tests++;
      if (fire !== (k == 7)) begin n_fail++; $display("FAIL midfire_repress k=%0d got=%b exp=%b", k, fire, k == 7); end
    end
    do_reset();
    trig_raw = 1'b1;
    for (int k = 1; k <= 30; k++) step();
    n_tests++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL jamreset_pre got=%b exp=1", error); end
    reset = 1'b1;
    #1;
    n_tests += 2;
    if (error !== 1'b0) begin n_fail++; $display("FAIL jamreset_error got=%b exp=0", error); end
    if (fire !== 1'b0) begin n_fail++; $display("FAIL jamreset_fire got=%b exp=0", fire); end
    trig_raw = 1'b0;
    step();
    step();
    reset = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      n_tests++;
      if (fire !== 1'b0 || error !== 1'b0) begin
        n_fail++;
        $display("FAIL jamreset_after k=%0d fire=%b error=%b exp=0,0", k, fire, error);
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    trig_raw = 1'b0;
    arm = 1'b0;
    n_tests = 0;
    n_fail = 0;
    test_reset();
    test_clean();
    test_bounce();
    test_jam();
    test_cooldown();
    test_arm();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/trigger_conditioner.md
TRIGGER_CONDITIONER -- requirements
Module: trigger_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive clk cycles a synchronized level must hold to be accepted.
REQ-002 SHALL have parameter COOLDOWN_CYCLES, default 10000000, minimum clk cycles between accepted release and next armable press.
REQ-003 SHALL have parameter HOLD_ERR_CYCLES, default 200000000, clk cycles of continuous hold after a shot that declare a jam.
REQ-004 SHALL have parameter CNT_W, default 28, width of the shared cycle counter; must hold the largest of the three cycle parameters.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 trig_raw  input  1  raw, unsynchronized, bouncing trigger button, active-high.
REQ-008 arm  input  1  level; new presses are accepted only while high.
REQ-009 fire  output  1  registered single-cycle shot pulse; drives the shot counter's fire input.
REQ-010 error  output  1  registered jam flag; drives the shot counter's error input.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 trig_raw SHALL pass through a 2-flop synchronizer; all logic uses the synchronized trig_s only.
REQ-013 FSM states SHALL be IDLE, DB_PRESS, FIRE, HELD, DB_RELEASE, COOLDOWN, JAM; one CNT_W counter, cleared on every state change.
REQ-014 IDLE: trig_s=1 and arm=1 -> DB_PRESS; otherwise stay.
REQ-015 DB_PRESS: trig_s=0 or arm=0 -> IDLE; count reaches DEBOUNCE_CYCLES-1 with trig_s=1 -> FIRE.
REQ-016 FIRE: exactly one cycle, fire=1, unconditionally -> HELD.
REQ-017 HELD: trig_s=0 -> DB_RELEASE; count reaches HOLD_ERR_CYCLES-1 with trig_s=1 -> JAM.
REQ-018 DB_RELEASE: trig_s=1 -> HELD (hold count restarts); trig_s=0 for DEBOUNCE_CYCLES -> COOLDOWN.
REQ-019 COOLDOWN: trigger ignored; after COOLDOWN_CYCLES -> IDLE.
REQ-020 JAM: error=1; trig_s=0 for DEBOUNCE_CYCLES consecutive cycles -> COOLDOWN, error cleared on that transition; any trig_s=1 restarts the release count.
REQ-021 fire SHALL be high only in FIRE, never two consecutive cycles, at most one pulse per press.
REQ-022 error SHALL never change in the cycle fire rises or is high (downstream samples error on fire edge).
REQ-023 Latency trig_raw rise to fire: 2 sync cycles + DEBOUNCE_CYCLES + 1 register cycle, bounce-free input.
REQ-024 arm falling in HELD, DB_RELEASE, COOLDOWN or JAM SHALL have no effect.
REQ-025 Counter SHALL saturate, never wrap, in any state.

Reset
REQ-026 Reset SHALL force IDLE, counter 0, both synchronizer flops 0, fire=0, error=0, busy=0 immediately.
REQ-027 Reset asserted mid-shot (FIRE) SHALL truncate the pulse; no further pulse until a fresh debounced press after release.
REQ-028 After reset release with trig_raw held high and arm=1, the block SHALL debounce and fire once.

Structure
REQ-029 Shared package trigger_pkg SHALL hold the state enum and the default values of the three cycle parameters.
REQ-030 One sub-module sync_2ff (1-bit, asynchronous reset) SHALL implement the synchronizer; all else in trigger_conditioner.

Verification (DEBOUNCE=4, COOLDOWN=8, HOLD_ERR=20)
REQ-031 Clean press, arm=1, held 10 cycles then released -> one fire pulse exactly 7 cycles after rise; busy high to end of cooldown; error=0.
REQ-032 Press with 3-cycle bounce glitches (high 2, low 1, repeat) then stable high -> single fire, timed from last stable rise.
REQ-033 Hold 30 cycles after fire -> error rises 20 cycles after HELD entry; release 4 stable cycles -> error falls, COOLDOWN 8 cycles, IDLE.
REQ-034 Second press during COOLDOWN -> no fire; same press held past cooldown end -> fire after 4 debounce cycles.
REQ-035 arm=0 during press -> no fire; arm drops in DB_PRESS cycle 2 -> IDLE, no fire.
REQ-036 Reset asserted in FIRE cycle and in JAM -> fire and error 0 same cycle; next shot only after release and new press.
